// File: rtl/des.sv
// Single-DES engine: 16-round fully pipelined datapath, one block per clock.
// Each block carries its own key state and direction bit down the pipe.
module des (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] desIn,
    input  logic [63:0] keyIn,
    input  logic        decrypt,
    output logic [63:0] desOut
);

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [3:0] S_T [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
    };

    // Encrypt rotates C/D left before each round; decrypt starts from K16
    // (the unrotated PC-1 state) and rotates right by the mirrored schedule.
    localparam int SHL_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SHR_T [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    function automatic logic [63:0] f_ip(input logic [63:0] x);
        for (int i = 0; i < 64; i++) f_ip[63-i] = x[64-IP_T[i]];
    endfunction

    function automatic logic [63:0] f_fp(input logic [63:0] x);
        for (int i = 0; i < 64; i++) f_fp[63-i] = x[64-FP_T[i]];
    endfunction

    function automatic logic [55:0] f_pc1(input logic [63:0] x);
        for (int i = 0; i < 56; i++) f_pc1[55-i] = x[64-PC1_T[i]];
    endfunction

    function automatic logic [47:0] f_pc2(input logic [55:0] x);
        for (int i = 0; i < 48; i++) f_pc2[47-i] = x[56-PC2_T[i]];
    endfunction

    function automatic logic [27:0] f_rol(input logic [27:0] c, input int n);
        case (n)
            1:       f_rol = {c[26:0], c[27]};
            2:       f_rol = {c[25:0], c[27:26]};
            default: f_rol = c;
        endcase
    endfunction

    function automatic logic [27:0] f_ror(input logic [27:0] c, input int n);
        case (n)
            1:       f_ror = {c[0], c[27:1]};
            2:       f_ror = {c[1:0], c[27:2]};
            default: f_ror = c;
        endcase
    endfunction

    function automatic logic [31:0] f_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [5:0]  six;
        logic [31:0] s;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            s[31-4*b -: 4] = S_T[b*64 + int'({six[5], six[0], six[4:1]})];
        end
        for (int i = 0; i < 32; i++) f_f[31-i] = s[32-P_T[i]];
    endfunction

    logic [31:0] r_l   [0:16];
    logic [31:0] r_r   [0:16];
    logic [55:0] r_cd  [0:15];
    logic        r_dec [0:15];

    logic [55:0] w_cd  [1:16];
    logic [47:0] w_k   [1:16];
    logic [31:0] w_f   [1:16];
    logic [63:0] w_ip;
    logic [55:0] w_pc1;

    assign w_ip  = f_ip(desIn);
    assign w_pc1 = f_pc1(keyIn);

    always_comb begin
        for (int r = 1; r <= 16; r++) begin
            if (r_dec[r-1]) begin
                w_cd[r] = {f_ror(r_cd[r-1][55:28], SHR_T[r-1]),
                           f_ror(r_cd[r-1][27:0],  SHR_T[r-1])};
            end else begin
                w_cd[r] = {f_rol(r_cd[r-1][55:28], SHL_T[r-1]),
                           f_rol(r_cd[r-1][27:0],  SHL_T[r-1])};
            end
            w_k[r] = f_pc2(w_cd[r]);
            w_f[r] = f_f(r_r[r-1], w_k[r]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r <= 16; r++) begin
                r_l[r] <= '0;
                r_r[r] <= '0;
            end
            for (int r = 0; r <= 15; r++) begin
                r_cd[r]  <= '0;
                r_dec[r] <= 1'b0;
            end
        end else begin
            r_l[0]   <= w_ip[63:32];
            r_r[0]   <= w_ip[31:0];
            r_cd[0]  <= w_pc1;
            r_dec[0] <= decrypt;
            for (int r = 1; r <= 16; r++) begin
                r_l[r] <= r_r[r-1];
                r_r[r] <= r_l[r-1] ^ w_f[r];
            end
            for (int r = 1; r <= 15; r++) begin
                r_cd[r]  <= w_cd[r];
                r_dec[r] <= r_dec[r-1];
            end
        end
    end

    assign desOut = f_fp({r_r[16], r_l[16]});

endmodule

// File: tb/tb_des.sv
// Scoreboard bench for the pipelined DES: stimulus pushes expected blocks
// tagged with their due edge; a negedge monitor pops and compares.
module tb_des;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] desIn;
    logic [63:0] keyIn;
    logic        decrypt;
    logic [63:0] desOut;

    des dut (
        .clk    (clk),
        .reset  (reset),
        .desIn  (desIn),
        .keyIn  (keyIn),
        .decrypt(decrypt),
        .desOut (desOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] exp;
        int          due;
        string       tag;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [63:0] K1 = 64'h10316E028C8F3B4A;
    localparam logic [63:0] KP = 64'h0101010101010101;
    localparam logic [63:0] KZ = 64'h0000000000000000;

    logic [63:0] ct [4];
    logic [63:0] pt [4];

    always @(posedge clk) edge_n++;

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && q.size() != 0 && q[0].due <= edge_n) begin
            m_e = q.pop_front();
            if (m_e.due < edge_n) begin
                checks++;
                errors++;
                $display("FAIL %s late due %0d now %0d", m_e.tag, m_e.due, edge_n);
            end else begin
                check(m_e.tag, desOut, m_e.exp);
            end
        end
    end

    task automatic apply(input logic [63:0] d, input logic [63:0] k,
                         input logic dec, input logic [63:0] e,
                         input string tag);
        @(negedge clk);
        desIn   = d;
        keyIn   = k;
        decrypt = dec;
        q.push_back('{exp: e, due: edge_n + 17, tag: tag});
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain timeout pending %0d", q.size());
            q.delete();
        end
    endtask

    initial begin
        ct[0] = 64'h95F8A5E5DD31D900; pt[0] = 64'h8000000000000000;
        ct[1] = 64'hDD7F121CA5015619; pt[1] = 64'h4000000000000000;
        ct[2] = 64'h2E8653104F3834EA; pt[2] = 64'h2000000000000000;
        ct[3] = 64'h4BD388FF6CD81D4F; pt[3] = 64'h1000000000000000;

        reset   = 1'b1;
        desIn   = 64'h0123456789ABCDEF;
        keyIn   = K1;
        decrypt = 1'b0;
        #2;
        check("rst_async", desOut, 64'h0);
        repeat (3) begin
            @(negedge clk);
            check("rst_hold", desOut, 64'h0);
        end
        @(negedge clk);
        reset = 1'b0;

        apply(64'h0, K1, 1'b0, 64'h82DCBAFBDEAB6602, "enc_k1");
        apply(64'h82DCBAFBDEAB6602, K1, 1'b1, 64'h0, "dec_k1");
        for (int i = 0; i < 4; i++) apply(ct[i], KP, 1'b1, pt[i], "stream");
        for (int i = 0; i < 2; i++) begin
            apply(64'h0, K1, 1'b0, 64'h82DCBAFBDEAB6602, "alt_enc");
            apply(64'h82DCBAFBDEAB6602, K1, 1'b1, 64'h0, "alt_dec");
        end
        apply(ct[0], KZ, 1'b1, pt[0], "par_k0");
        apply(ct[0], KP, 1'b1, pt[0], "par_k1");
        apply(pt[1], KZ, 1'b0, ct[1], "par_enc0");
        apply(pt[1], KP, 1'b0, ct[1], "par_enc1");
        repeat (20) apply(64'h0, K1, 1'b0, 64'h82DCBAFBDEAB6602, "hold");
        drain();

        for (int i = 0; i < 4; i++) apply(ct[i], KP, 1'b1, pt[i], "pre_rst");
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid", desOut, 64'h0);
        q.delete();
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_hold", desOut, 64'h0);
        end
        reset = 1'b0;

        for (int i = 0; i < 4; i++) apply(ct[i], KP, 1'b1, pt[i], "refill");
        apply(pt[2], KP, 1'b0, ct[2], "refill_enc");
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/des.md
DES -- requirements
Module: des

Interface
REQ-001 The block SHALL have these ports: clk, input, 1 bit, single clock; all state updates on the rising edge.
REQ-002 The block SHALL have these ports: reset, input, 1 bit, asynchronous, active-high; clears all pipeline state.
REQ-003 The block SHALL have these ports: desIn, input, 64 bits, data block (plaintext when encrypting, ciphertext when decrypting).
REQ-004 The block SHALL have these ports: keyIn, input, 64 bits, DES key including 8 parity bits.
REQ-005 The block SHALL have these ports: decrypt, input, 1 bit; 1 = decrypt, 0 = encrypt.
REQ-006 The block SHALL have these ports: desOut, output, 64 bits, result block.
REQ-007 The block SHALL have no parameters.

Function
REQ-008 The block SHALL implement single-DES per FIPS 46-3, with no deviation in any permutation or table: IP, FP, E, P, S1-S8, PC-1, PC-2 and the shift schedule.
REQ-009 Bit numbering SHALL be MSB-first: vector bit 63 = FIPS bit 1 and vector bit 0 = FIPS bit 64, for desIn, keyIn and desOut.
REQ-010 Key parity bits (FIPS bits 8,16,...,64 = vector bits 56,48,...,0) SHALL be ignored; parity SHALL NOT be checked.
REQ-011 Key schedule: PC-1 splits the key into C/D halves; left-rotate per round by 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; PC-2 gives subkeys K1..K16.
REQ-012 decrypt=1 SHALL apply the subkeys in order K16..K1; decrypt=0 SHALL apply them in order K1..K16.
REQ-013 Architecture SHALL be a fully pipelined 16-round datapath with one round per stage.
REQ-014 Throughput SHALL be one new block accepted on every rising edge.
REQ-015 The key state and the decrypt bit SHALL travel down the pipeline with their own data block.
REQ-016 Consequence of REQ-015: a change of keyIn or decrypt SHALL affect only blocks sampled at or after that edge.
REQ-017 Stage 0 register: at rising edge k, capture IP(desIn), the PC-1 output of keyIn, and decrypt.
REQ-018 Round stages 1..16 SHALL each be registered; stage r is updated at edge k+r.
REQ-019 Each round SHALL compute L' = R and R' = L xor f(R, Kr), using the key state of that stage.
REQ-020 desOut SHALL be FP(R16 || L16), combinational from the stage-16 register; the halves are swapped before FP.
REQ-021 Latency: the result for inputs sampled at edge k SHALL be valid on desOut after edge k+16 and remain valid until edge k+17.
REQ-022 No valid/ready handshake SHALL exist; a block presented on desIn is always accepted.
REQ-023 desOut SHALL follow stage 16 every cycle, including while the pipeline is filling.
REQ-024 Holding constant inputs for 17 or more cycles SHALL yield a stable correct desOut.

Reset
REQ-025 While reset=1, all pipeline registers (data, key state, decrypt) SHALL be 0, asynchronously and independent of clk.
REQ-026 Consequence of REQ-025: desOut SHALL be 64'h0000000000000000 during reset.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight blocks.
REQ-028 After reset deasserts, the first valid result SHALL appear 16 edges after the first sampling edge, per REQ-021.
REQ-029 Until the pipeline refills after reset, desOut SHALL show results of the zeroed stages, which are not meaningful data.

Verification
REQ-030 Encrypt vector: key 10316E028C8F3B4A, desIn 0000000000000000, decrypt=0 -> desOut 82DCBAFBDEAB6602 after edge k+16; the reverse direction with decrypt=1 returns 0000000000000000.
REQ-031 Decrypt vectors, key 0101010101010101, decrypt=1: 95F8A5E5DD31D900 -> 8000000000000000; DD7F121CA5015619 -> 4000000000000000; 2E8653104F3834EA -> 2000000000000000; 4BD388FF6CD81D4F -> 1000000000000000.
REQ-032 Streaming: apply the REQ-031 ciphertexts on 4 consecutive edges -> the 4 plaintexts appear on desOut on 4 consecutive cycles, starting 16 edges after the first.
REQ-033 Per-block mode: alternate decrypt=0/1 on consecutive edges with the same key -> each output matches the mode it was sampled with.
REQ-034 Parity independence: key 0000000000000000 vs 0101010101010101 with identical data -> identical desOut.
REQ-035 Reset: assert reset mid-stream -> desOut is 0 immediately; after release and refill, vectors match again.
